// File: rtl/input_layer_pingpong_controller.sv
// Ping-pong input layer: thresholds a pixel stream into active indices,
// captures one frame per bank and drains the other as an index stream.
module input_layer_pingpong_controller #(
  parameter int NUM_PIXELS  = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputsInbound,
  input  logic [PIXEL_WIDTH-1:0] pixelValue,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  input  logic                   abortFrame,
  input  logic                   dequeue,
  output logic                   readyForInputs,
  output logic                   outputsReady,
  output logic [INDEX_WIDTH-1:0] indexOut,
  output logic                   lastIndex,
  output logic                   queueEmpty,
  output logic                   emptyFrame,
  output logic [INDEX_WIDTH:0]   activeCount
);

  localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_PIX = INDEX_WIDTH'(NUM_PIXELS - 1);

  typedef logic [INDEX_WIDTH:0] cnt_t;

  logic [INDEX_WIDTH-1:0] bank [2][NUM_PIXELS];

  logic [INDEX_WIDTH-1:0] pix_cnt;
  cnt_t                   cap_cnt;
  cnt_t                   drain_left;
  cnt_t                   active_cnt;
  logic [AW-1:0]          rd_ptr;
  logic                   capture_full;
  logic                   bank_sel;
  logic                   empty_pulse;

  logic accept;
  logic hit;
  logic wr_en;
  logic last_pix;
  logic pop;
  logic swap;

  assign accept   = inputsInbound && !capture_full;
  assign hit      = pixelValue >= threshold;
  assign wr_en    = accept && hit && !abortFrame;
  assign last_pix = pix_cnt == LAST_PIX;
  assign pop      = dequeue && (drain_left != '0);
  // Swap when the drain bank is empty or its last entry leaves this edge;
  // an abort wins over a pending swap.
  assign swap     = capture_full && !abortFrame &&
                    ((drain_left == '0) ||
                     ((drain_left == cnt_t'(1)) && dequeue));

  // Capture write: the capture bank is bank_sel, the drain bank its complement.
  always_ff @(posedge clk) begin
    if (wr_en) bank[bank_sel][cap_cnt[AW-1:0]] <= pix_cnt;
  end

  // Capture counters, bank swap and drain pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt      <= '0;
      cap_cnt      <= '0;
      drain_left   <= '0;
      active_cnt   <= '0;
      rd_ptr       <= '0;
      capture_full <= 1'b0;
      bank_sel     <= 1'b0;
      empty_pulse  <= 1'b0;
    end else begin
      empty_pulse <= 1'b0;
      if (abortFrame) begin
        pix_cnt      <= '0;
        cap_cnt      <= '0;
        capture_full <= 1'b0;
      end else if (accept) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
        if (hit) cap_cnt <= cap_cnt + 1'b1;
        if (last_pix) capture_full <= 1'b1;
      end
      if (swap) begin
        bank_sel     <= ~bank_sel;
        drain_left   <= cap_cnt;
        active_cnt   <= cap_cnt;
        rd_ptr       <= '0;
        cap_cnt      <= '0;
        capture_full <= 1'b0;
        empty_pulse  <= cap_cnt == '0;
      end else if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        drain_left <= drain_left - 1'b1;
      end
    end
  end

  assign readyForInputs = ~capture_full;
  assign outputsReady   = drain_left != '0;
  assign queueEmpty     = ~outputsReady;
  assign lastIndex      = drain_left == cnt_t'(1);
  assign indexOut       = outputsReady ? bank[~bank_sel][rd_ptr] : '0;
  assign emptyFrame     = empty_pulse;
  assign activeCount    = active_cnt;

endmodule

// File: tb/tb_input_layer_pingpong_controller.sv
// Bench for input_layer_pingpong_controller: scoreboarded index stream
// plus directed checks on swap timing, empty frames, abort and reset.
module tb_input_layer_pingpong_controller;

  localparam int NP = 16;
  localparam int PW = 8;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inputsInbound = 1'b0;
  logic [PW-1:0] pixelValue = '0;
  logic [PW-1:0] threshold = '0;
  logic          abortFrame = 1'b0;
  logic          dequeue = 1'b0;
  logic          readyForInputs;
  logic          outputsReady;
  logic [IW-1:0] indexOut;
  logic          lastIndex;
  logic          queueEmpty;
  logic          emptyFrame;
  logic [IW:0]   activeCount;

  int tests = 0;
  int fails = 0;
  int pix_idx = 0;
  logic [IW:0] sb[$];
  logic [IW:0] pend[$];

  input_layer_pingpong_controller #(
    .NUM_PIXELS(NP), .PIXEL_WIDTH(PW), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .inputsInbound(inputsInbound),
    .pixelValue(pixelValue), .threshold(threshold),
    .abortFrame(abortFrame), .dequeue(dequeue),
    .readyForInputs(readyForInputs), .outputsReady(outputsReady),
    .indexOut(indexOut), .lastIndex(lastIndex), .queueEmpty(queueEmpty),
    .emptyFrame(emptyFrame), .activeCount(activeCount)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // Pop the scoreboard whenever the consumer takes an index.
  always @(negedge clk) begin
    logic [IW:0] e;
    if (!reset && dequeue && outputsReady) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("index", indexOut, e[IW-1:0]);
        chk("last", lastIndex, e[IW]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input logic [PW-1:0] v, input logic [PW-1:0] thr,
                            input bit gap);
    int n;
    logic [IW:0] t;
    n = 0;
    if (gap) begin
      inputsInbound = 1'b0;
      step();
    end
    inputsInbound = 1'b1;
    pixelValue = v;
    threshold = thr;
    @(negedge clk);
    while (!readyForInputs && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk("ready_timeout", n, 0);
    step();
    inputsInbound = 1'b0;
    if (v >= thr) pend.push_back({1'b0, IW'(pix_idx)});
    if (pix_idx == NP - 1) begin
      if (pend.size() != 0) begin
        t = pend.pop_back();
        t[IW] = 1'b1;
        pend.push_back(t);
      end
      foreach (pend[k]) sb.push_back(pend[k]);
      pend.delete();
      pix_idx = 0;
    end else begin
      pix_idx++;
    end
  endtask

  task automatic send_pixels(input logic [NP-1:0] mask,
                             input logic [PW-1:0] thr,
                             input bit gap, input int n);
    logic [PW-1:0] v;
    for (int i = 0; i < n; i++) begin
      if (mask[i]) v = (i % 2 == 1) ? 8'd128 : 8'd200;
      else         v = (i % 2 == 1) ? 8'd127 : 8'd0;
      push_pixel(v, thr, gap);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || outputsReady) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_ready", outputsReady, 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", readyForInputs, 1);
    chk("rst_oready", outputsReady, 0);
    chk("rst_qempty", queueEmpty, 1);
    chk("rst_index", indexOut, 0);
    chk("rst_last", lastIndex, 0);
    chk("rst_empty", emptyFrame, 0);
    chk("rst_count", activeCount, 0);
  endtask

  initial begin
    #1;
    chk_reset_outs();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic frame with continuous dequeue: swap one edge after last pixel.
    dequeue = 1'b1;
    send_pixels(16'h8024, 8'd128, 1'b0, 16);
    chk("t1_ready_low", readyForInputs, 0);
    chk("t1_not_yet", outputsReady, 0);
    step();
    chk("t1_oready", outputsReady, 1);
    chk("t1_first", indexOut, 2);
    chk("t1_count", activeCount, 3);
    chk("t1_ready_back", readyForInputs, 1);
    wait_drain();

    // Second frame backs up behind an undrained first frame.
    dequeue = 1'b0;
    send_pixels(16'h000A, 8'd128, 1'b0, 16);
    send_pixels(16'h0210, 8'd128, 1'b0, 16);
    repeat (3) step();
    chk("t2_ready_low", readyForInputs, 0);
    chk("t2_oready", outputsReady, 1);
    chk("t2_head", indexOut, 1);
    dequeue = 1'b1;
    step();
    dequeue = 1'b0;
    chk("t2_last_flag", lastIndex, 1);
    chk("t2_tail", indexOut, 3);
    dequeue = 1'b1;
    step();
    dequeue = 1'b0;
    chk("t2_swap_oready", outputsReady, 1);
    chk("t2_swap_head", indexOut, 4);
    chk("t2_swap_ready", readyForInputs, 1);
    chk("t2_swap_count", activeCount, 2);
    dequeue = 1'b1;
    wait_drain();

    // All-inactive frame.
    send_pixels(16'h0000, 8'd128, 1'b0, 16);
    step();
    chk("t3_pulse", emptyFrame, 1);
    chk("t3_count", activeCount, 0);
    chk("t3_oready", outputsReady, 0);
    chk("t3_qempty", queueEmpty, 1);
    chk("t3_ready", readyForInputs, 1);
    step();
    chk("t3_pulse_end", emptyFrame, 0);

    // Threshold zero: every pixel active, count reaches NP.
    send_pixels(16'h0000, 8'd0, 1'b0, 16);
    step();
    chk("t4_count", activeCount, NP);
    wait_drain();

    // Gapped stream, then abort with a colliding pixel.
    send_pixels(16'h8024, 8'd128, 1'b1, 16);
    step();
    chk("t5_count", activeCount, 3);
    wait_drain();
    send_pixels(16'h00A5, 8'd128, 1'b0, 8);
    abortFrame = 1'b1;
    inputsInbound = 1'b1;
    pixelValue = 8'd255;
    threshold = 8'd0;
    step();
    abortFrame = 1'b0;
    inputsInbound = 1'b0;
    pend.delete();
    pix_idx = 0;
    send_pixels(16'h0181, 8'd128, 1'b0, 16);
    step();
    chk("t5_abort_count", activeCount, 3);
    wait_drain();

    // Reset between edges while draining and capturing.
    dequeue = 1'b0;
    send_pixels(16'h0048, 8'd128, 1'b0, 16);
    step();
    chk("t6_pre_oready", outputsReady, 1);
    send_pixels(16'h0003, 8'd128, 1'b0, 6);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outs();
    sb.delete();
    pend.delete();
    pix_idx = 0;
    step();
    reset = 1'b0;
    dequeue = 1'b1;
    send_pixels(16'h0401, 8'd128, 1'b0, 16);
    step();
    chk("t6_count", activeCount, 2);
    wait_drain();

    chk("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_layer_pingpong_controller.md
Name: input_layer_pingpong_controller

Overview:
- Parametrised successor to the single-bit input layer controller.
- Accepts a streamed frame of multi-bit pixels, thresholds each pixel, and records the indices of active pixels into one of two ping-pong index banks.
- Presents the completed bank to the first hidden layer as a dequeue-driven index stream while the next frame is captured into the other bank.
- Sits between the image source and the first neuron layer.

Parameters:
NUM_PIXELS, 784, pixels per frame; also the depth of each bank.
PIXEL_WIDTH, 8, bits per pixel value.
INDEX_WIDTH, 10, width of a pixel index; must satisfy 2^INDEX_WIDTH >= NUM_PIXELS.

Ports:
clk  in  1  single clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high reset.
inputsInbound  in  1  source asserts while pixelValue carries a valid pixel.
pixelValue  in  PIXEL_WIDTH  current pixel, unsigned.
threshold  in  PIXEL_WIDTH  pixel is active when pixelValue >= threshold; sampled per pixel.
abortFrame  in  1  discards the partially captured frame.
dequeue  in  1  consumer pops the current indexOut.
readyForInputs  out  1  a pixel is accepted on an edge where inputsInbound && readyForInputs.
outputsReady  out  1  drain bank holds at least one index; indexOut is valid.
indexOut  out  INDEX_WIDTH  head index of the drain bank.
lastIndex  out  1  indexOut is the final index of its frame.
queueEmpty  out  1  drain bank is empty; equals ~outputsReady.
emptyFrame  out  1  one-cycle pulse when a frame with zero active pixels is swapped in.
activeCount  out  INDEX_WIDTH+1  number of indices loaded into the current drain bank at swap.

Behaviour:
- Reset (async, any time, including mid-frame or mid-drain):
  - Outputs: readyForInputs=1, outputsReady=0, queueEmpty=1, indexOut=0, lastIndex=0, emptyFrame=0, activeCount=0.
  - Internal: pixel counter=0, capture count=0, drain count and read pointer=0, captureFull=0, bank select=0.
  - Bank contents are don't-care.
- Capture side, per accepted pixel:
  - If pixelValue >= threshold, the current pixel counter value is written at capture[count] and count increments.
  - The pixel counter increments on every accepted pixel, active or not.
  - inputsInbound low mid-frame pauses capture; the counter holds and nothing is lost.
- Frame completion:
  - The edge accepting pixel NUM_PIXELS-1 wraps the pixel counter to 0, sets captureFull=1 and drives readyForInputs=0.
- Swap:
  - Condition, evaluated on each edge while captureFull=1: drain count==0, or (drain count==1 && dequeue).
  - When the condition holds, that edge does all of the following:
    - flips bank select and moves capture count into drain count and activeCount;
    - resets read pointer and capture count to 0;
    - clears captureFull and sets readyForInputs=1.
  - When the condition fails, readyForInputs stays 0. The source is back-pressured; pixels are never dropped.
  - Minimum latency is 2 edges: last pixel accepted at edge N, swap at edge N+1, first indexOut valid after edge N+1.
- Empty frame:
  - If capture count==0 at swap, emptyFrame pulses for one cycle and outputsReady stays 0.
- Drain side:
  - indexOut = drain[readPtr], driven from registered state.
  - lastIndex = outputsReady && (readPtr == drainCount-1).
  - dequeue with outputsReady=1 advances readPtr.
  - Dequeue of the last entry: outputsReady falls and queueEmpty rises after that edge, unless a swap loads a non-empty frame on the same edge, in which case outputsReady stays 1 and indexOut shows the new frame's first index.
  - dequeue with outputsReady=0 is ignored.
- abortFrame (synchronous):
  - Clears the pixel counter and capture count; a pending captureFull is also cleared.
  - The drain side is unaffected.
  - abortFrame has priority over a pixel accepted in the same cycle.
- Arithmetic:
  - Counters are unsigned.
  - The threshold compare is an unsigned PIXEL_WIDTH comparison.
  - threshold=0 makes every pixel active, so count reaches NUM_PIXELS; counts are sized INDEX_WIDTH+1 to hold this.

Test Plan:
- NUM_PIXELS=16, threshold=128, pixels 200 at indices 2, 5, 15, others 0, dequeue held 1 -> swap one edge after the last pixel; indexOut 2, 5, 15 on consecutive cycles; lastIndex only with 15; activeCount=3.
- Second frame streamed while frame 1 is undrained (dequeue=0) -> after pixel 15, readyForInputs=0 and stays 0; the first dequeue of the last frame-1 entry swaps on that edge; outputsReady stays 1 and indexOut shows frame 2's first index.
- All-zero frame -> emptyFrame pulses once, activeCount=0, outputsReady stays 0, readyForInputs returns to 1.
- threshold=0 -> 16 indices 0..15 emitted, activeCount=16, no overflow.
- inputsInbound toggled every other cycle mid-frame -> indices identical to the continuous case; abortFrame after pixel 7, then a full frame -> only the new frame's indices appear.
- reset asserted mid-capture and mid-drain, asynchronously between edges -> all outputs take their reset values immediately; the next frame is captured correctly from index 0.
